uart_txd_ctr: RTL and testbench

UART_TXD_CTR -- requirements
Module: uart_txd_ctr

---
 rtl/uart_txd_ctr_pkg.sv | 44 ++++
 rtl/uart_tx_wdog.sv | 27 ++
 rtl/uart_txd_ctr.sv | 115 +++++++++++
 tb/tb_uart_txd_ctr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_txd_ctr_pkg.sv
// Shared definitions for the parameter-frame UART link, used by both the
// transmit controller and the receive-side parser.
package uart_txd_ctr_pkg;

   localparam logic [7:0] HDR_B0 = 8'hFF;
   localparam logic [7:0] HDR_B1 = 8'hF0;
   localparam logic [7:0] HDR_B2 = 8'hA0;
   localparam logic [7:0] TRL_B0 = 8'h0D;
   localparam logic [7:0] TRL_B1 = 8'h0A;

   localparam int         FRAME_LEN = 8;
   localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } tx_state_t;

   // All-ones adjust is reserved as a marker and is sent without the +1 offset.
   function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                             input logic [7:0]  div,
                                             input logic [15:0] adj);
      logic [7:0] adj_hi;
      logic [7:0] adj_lo;
      logic [7:0] b;
      adj_hi = (adj == 16'hFFFF) ? 8'hFF : adj[15:8] + 8'd1;
      adj_lo = (adj == 16'hFFFF) ? 8'hFF : adj[7:0] + 8'd1;
      b = 8'h00;
      case (idx)
         3'd0:    b = HDR_B0;
         3'd1:    b = HDR_B1;
         3'd2:    b = HDR_B2;
         3'd3:    b = div;
         3'd4:    b = adj_hi;
         3'd5:    b = adj_lo;
         3'd6:    b = TRL_B0;
         default: b = TRL_B1;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_wdog.sv
// Per-byte watchdog: counts enabled cycles and flags the cycle whose
// increment would reach TIMEOUT.
module uart_tx_wdog #(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [15:0] count;

   assign expire = enable && (count == TIMEOUT - 16'd1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear || expire) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/uart_txd_ctr.sv
// Sends the 8-byte divider/adjust parameter frame through a byte UART,
// one tx_start per byte, aborting the frame if a byte never completes.
module uart_txd_ctr
   import uart_txd_ctr_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        send_req,
   input  logic [7:0]  divNum_in,
   input  logic [15:0] adjNum_in,
   input  logic        tx_done,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        frame_done,
   output logic        tx_err
);

   tx_state_t   state, state_next;
   logic [2:0]  idx, idx_next;
   logic [7:0]  div_lat;
   logic [15:0] adj_lat;
   logic [7:0]  div_src;
   logic [15:0] adj_src;
   logic        latch_en;
   logic        abort;
   logic        wd_clear;
   logic        wd_en;
   logic        wd_expire;

   uart_tx_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .enable (wd_en),
      .expire (wd_expire)
   );

   // The first byte is loaded on the accepting edge, before the latches settle.
   assign div_src = latch_en ? divNum_in : div_lat;
   assign adj_src = latch_en ? adjNum_in : adj_lat;

   always_comb begin
      state_next = state;
      idx_next   = idx;
      latch_en   = 1'b0;
      abort      = 1'b0;
      wd_clear   = 1'b0;
      wd_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (send_req) begin
               latch_en   = 1'b1;
               idx_next   = 3'd0;
               state_next = ST_START;
            end
         end
         ST_START: begin
            wd_clear   = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done) begin
               if (idx == LAST_IDX) begin
                  state_next = ST_DONE;
               end else begin
                  idx_next   = idx + 3'd1;
                  state_next = ST_START;
               end
            end else begin
               wd_en = 1'b1;
               if (wd_expire) begin
                  abort      = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         idx        <= 3'd0;
         div_lat    <= '0;
         adj_lat    <= '0;
         tx_start   <= 1'b0;
         tx_data    <= 8'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (latch_en) begin
            div_lat <= divNum_in;
            adj_lat <= adjNum_in;
         end
         tx_start <= (state_next == ST_START);
         if (state_next == ST_START) begin
            tx_data <= frame_byte(idx_next, div_src, adj_src);
         end
         busy       <= (state_next != ST_IDLE);
         frame_done <= (state_next == ST_DONE);
         tx_err     <= abort;
      end
   end

endmodule

// File: tb/tb_uart_txd_ctr.sv
// Directed-plus-random bench for the parameter-frame transmitter, checked
// against a byte-list model of the frame and pulse counters.
module tb_uart_txd_ctr;

   localparam logic [15:0] TMO   = 16'd20;
   localparam int          TMO_I = 20;

   logic        clk;
   logic        rst;
   logic        send_req;
   logic [7:0]  divNum_in;
   logic [15:0] adjNum_in;
   logic        tx_done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic        frame_done;
   logic        tx_err;

   int nCompared   = 0;
   int nMismatched = 0;
   int startCnt    = 0;
   int doneCnt     = 0;
   int errCnt      = 0;
   int expStarts   = 0;
   int expDone     = 0;
   int expErr      = 0;
   bit spamOn      = 1'b0;

   uart_txd_ctr #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .send_req   (send_req),
      .divNum_in  (divNum_in),
      .adjNum_in  (adjNum_in),
      .tx_done    (tx_done),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .busy       (busy),
      .frame_done (frame_done),
      .tx_err     (tx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_start === 1'b1)   startCnt++;
      if (frame_done === 1'b1) doneCnt++;
      if (tx_err === 1'b1)     errCnt++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "[TB] simulation bound exceeded");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (spamOn) begin
         send_req  = 1'b1;
         divNum_in = 8'($urandom);
         adjNum_in = 16'($urandom);
      end
   endtask

   task automatic checkCounts(input string tag);
      checkOutput({tag, "_starts"}, 32'(startCnt), 32'(expStarts));
      checkOutput({tag, "_done"}, 32'(doneCnt), 32'(expDone));
      checkOutput({tag, "_err"}, 32'(errCnt), 32'(expErr));
   endtask

   // One frame transaction; stopIdx >= 0 halts at that byte by timeout or by reset.
   task automatic applyStimulus(input logic [7:0] div, input logic [15:0] adj,
                                input int stopIdx, input bit stopByReset,
                                input bit spam, input int spurIdx, input int fixedDelay);
      logic [7:0] expBytes [8];
      int waitCyc;
      int delay;
      expBytes[0] = 8'hFF;
      expBytes[1] = 8'hF0;
      expBytes[2] = 8'hA0;
      expBytes[3] = div;
      expBytes[4] = (adj == 16'hFFFF) ? 8'hFF : 8'((int'(adj) / 256 + 1) % 256);
      expBytes[5] = (adj == 16'hFFFF) ? 8'hFF : 8'((int'(adj) % 256 + 1) % 256);
      expBytes[6] = 8'h0D;
      expBytes[7] = 8'h0A;

      send_req  = 1'b1;
      divNum_in = div;
      adjNum_in = adj;
      spamOn    = spam;
      tick();
      if (!spam) begin
         send_req  = 1'b0;
         divNum_in = 8'($urandom);
         adjNum_in = 16'($urandom);
      end

      for (int i = 0; i < 8; i++) begin
         waitCyc = 0;
         while (tx_start !== 1'b1 && waitCyc < 50) begin
            tick();
            waitCyc++;
         end
         checkOutput("start_latency", 32'(waitCyc), 32'd0);
         if (tx_start !== 1'b1) begin
            spamOn   = 1'b0;
            send_req = 1'b0;
            return;
         end
         expStarts++;
         checkOutput("tx_data", 32'(tx_data), 32'(expBytes[i]));
         checkOutput("busy_in_frame", 32'(busy), 32'd1);
         if (i == spurIdx) tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         checkOutput("no_restart", 32'(tx_start), 32'd0);

         if (i == stopIdx) begin
            if (stopByReset) begin
               repeat (3) tick();
               spamOn   = 1'b0;
               send_req = 1'b0;
               rst      = 1'b0;
               tick();
               rst = 1'b1;
               checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
               checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
               checkOutput("rst_busy", 32'(busy), 32'd0);
               checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
               checkOutput("rst_tx_err", 32'(tx_err), 32'd0);
               repeat (30) tick();
               checkCounts("after_reset");
            end else begin
               waitCyc = 0;
               while (tx_err !== 1'b1 && waitCyc < TMO_I + 10) begin
                  tick();
                  waitCyc++;
               end
               checkOutput("tmo_latency", 32'(waitCyc), 32'(TMO_I));
               checkOutput("busy_after_err", 32'(busy), 32'd0);
               spamOn   = 1'b0;
               send_req = 1'b0;
               tick();
               checkOutput("err_pulse_width", 32'(tx_err), 32'd0);
               expErr++;
               checkCounts("after_timeout");
            end
            return;
         end

         delay = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, TMO_I));
         repeat (delay - 1) tick();
         checkOutput("tx_data_hold", 32'(tx_data), 32'(expBytes[i]));
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end

      checkOutput("frame_done", 32'(frame_done), 32'd1);
      checkOutput("busy_in_done", 32'(busy), 32'd1);
      spamOn   = 1'b0;
      send_req = 1'b0;
      tick();
      checkOutput("frame_done_width", 32'(frame_done), 32'd0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      expDone++;
      checkCounts("after_frame");
   endtask

   initial begin
      rst       = 1'b0;
      send_req  = 1'b0;
      divNum_in = 8'd0;
      adjNum_in = 16'd0;
      tx_done   = 1'b0;
      repeat (3) tick();
      checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
      checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
      checkOutput("reset_tx_err", 32'(tx_err), 32'd0);
      rst = 1'b1;
      tick();

      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      checkOutput("idle_done_busy", 32'(busy), 32'd0);
      checkOutput("idle_done_start", 32'(tx_start), 32'd0);
      tick();
      checkOutput("idle_done_start2", 32'(tx_start), 32'd0);

      $display("[TB] basic frame 7C/1234");
      applyStimulus(8'h7C, 16'h1234, -1, 1'b0, 1'b0, -1, 10);
      $display("[TB] adjust special cases");
      applyStimulus(8'h55, 16'hFFFF, -1, 1'b0, 1'b0, -1, 0);
      applyStimulus(8'h01, 16'h12FF, -1, 1'b0, 1'b0, -1, 0);
      applyStimulus(8'hC3, 16'hFF00, -1, 1'b0, 1'b0, -1, 0);
      $display("[TB] request spam mid-frame");
      applyStimulus(8'h3C, 16'hABCD, -1, 1'b0, 1'b1, -1, 0);
      $display("[TB] timeout on third byte then fresh frame");
      applyStimulus(8'h9A, 16'h00FF, 2, 1'b0, 1'b0, -1, 0);
      applyStimulus(8'h11, 16'h2222, -1, 1'b0, 1'b0, -1, 0);
      $display("[TB] reset while waiting on byte 5");
      applyStimulus(8'h42, 16'h5678, 5, 1'b1, 1'b0, -1, 0);
      applyStimulus(8'h24, 16'h8765, -1, 1'b0, 1'b0, -1, 0);
      $display("[TB] spurious tx_done in START and tx_done at timeout boundary");
      applyStimulus(8'h66, 16'h0102, -1, 1'b0, 1'b0, 3, 0);
      applyStimulus(8'h77, 16'h0304, -1, 1'b0, 1'b0, -1, TMO_I);
      $display("[TB] random frames");
      for (int k = 0; k < 6; k++) begin
         applyStimulus(8'($urandom), 16'($urandom), -1, 1'b0, (k % 2) == 1, -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
